fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- IF-stage program-counter unit that directly consumes `branchTaken` / `predictedBranchPC` from the branch prediction table.
- Owns the PC register and the IF/ID prediction record, and selects the next PC.
- Checks the prediction when the branch resolves in ID. On a mispredict it redirects fetch and flushes the wrong-path instruction.
- Drives `IF_PC` back into the predictor and the instruction memory.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- INST_BYTES, 4, PC increment per instruction.

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  pipeline advance; 0 = stall (hazard unit)
- branchTaken  in  1  predictor says taken, for `IF_PC`
- predictedBranchPC  in  64  predicted target, for `IF_PC`
- ID_INST  in  32  instruction currently in ID
- branchPC  in  64  resolved branch target computed in ID
- zero_flag  in  1  rs1 == rs2 in ID
- IF_PC  out  64  current fetch PC
- ID_PC  out  64  PC of the instruction in ID
- flush  out  1  kill the IF/ID instruction (insert bubble)
- redirect  out  1  mispredict detected this cycle
- branchCount  out  32  resolved branches (optional feature)
- mispredictCount  out  32  mispredicts (optional feature)

Behaviour:
- Reset (async, arst_n=0):
  - PC = RESET_PC, ID_PC = 0.
  - valid_ID = 0, predTaken_ID = 0, predTarget_ID = 0.
  - Counters = 0; flush = redirect = 0 once state is reset.
- Branch recognition: isBranch = valid_ID && ID_INST[6:0]==7'b1100011 && ID_INST[14:12]==3'b000 (BEQ). actualTaken = isBranch && zero_flag.
- Mispredict, combinational, evaluated from ID state every cycle:
  - a) isBranch, actualTaken, !predTaken_ID → target = branchPC.
  - b) isBranch, actualTaken, predTaken_ID, predTarget_ID != branchPC → target = branchPC.
  - c) valid_ID, predTaken_ID, !actualTaken (not-taken branch or non-branch alias) → target = ID_PC + INST_BYTES.
  - `redirect` = a|b|c.
  - `flush` = redirect && enable.
- Next PC, applied only when enable=1, in priority order:
  1. redirect → mispredict target.
  2. branchTaken → predictedBranchPC.
  3. otherwise PC + INST_BYTES.
  - All adds are modulo 2^64 (wrap, no trap).
- IF/ID record, loaded when enable=1:
  - ID_PC <= PC.
  - predTaken_ID <= branchTaken.
  - predTarget_ID <= predictedBranchPC.
  - valid_ID <= !redirect. A flushed slot carries no prediction, and the next cycle cannot re-detect a mispredict from it.
- enable=0: PC and IF/ID record hold. redirect may be high, but flush stays 0 and nothing is consumed. The mispredict is acted on in the first cycle enable=1.
- One redirect per resolved branch: after a redirect, ID holds a bubble for one cycle.
- Single-cycle latency: a prediction presented in cycle N is in `IF_PC` at N+1. A redirect in cycle N puts the target in `IF_PC` at N+1.
- Reset mid-operation discards all in-flight state immediately; the first fetch after release is RESET_PC.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - branchCount increments on each cycle with isBranch && enable.
  - mispredictCount increments on each cycle with flush.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: both ports driven constant 0, no counter flops synthesized.

Decomposition:
- Shared package `cpu_pkg`: OPCODE_BRANCH (7'b1100011), FUNCT3_BEQ, XLEN (64), INST_BYTES, RESET_PC default.
- The branch predictor imports the same opcode constant.
- One combinational sub-module: `mispredict_check`. It takes the ID record, ID_INST, zero_flag and branchPC, and returns redirect plus the correction target.
- PC register, IF/ID record and counters stay in the top.

Test Plan:
- Reset, then 4 cycles with enable=1, branchTaken=0 → IF_PC = 0x0, 0x4, 0x8, 0xC; flush never asserted.
- branchTaken=1, predictedBranchPC=0x100 at PC 0x8 → next IF_PC = 0x100. Next cycle BEQ in ID, zero_flag=1, branchPC=0x100 → no redirect.
- Predicted not-taken BEQ at ID_PC 0x20, zero_flag=1, branchPC=0x80 → redirect=flush=1, IF_PC = 0x80 next cycle. Following cycle valid_ID=0 and redirect=0.
- Predicted taken to 0x40 at ID_PC 0x30, zero_flag=0 → IF_PC = 0x34 next cycle. mispredictCount = 1 with BP_STATS_EN.
- Mispredict pending with enable=0 for 3 cycles → IF_PC and ID_PC constant, flush=0, redirect=1. On enable=1 → flush=1 and IF_PC = target next cycle.
- PC = 64'hFFFF_FFFF_FFFF_FFFC, no prediction → IF_PC wraps to 0x0. Assert arst_n=0 mid-run → IF_PC = RESET_PC immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the IF stage and the branch predictor.
package cpu_pkg;

  localparam int unsigned XLEN               = 64;
  localparam logic [6:0]  OPCODE_BRANCH      = 7'b1100011;
  localparam logic [2:0]  FUNCT3_BEQ         = 3'b000;
  localparam int unsigned INST_BYTES_DEFAULT = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  // Prediction record travelling with the instruction from IF into ID.
  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] pc;
  } if_id_t;

  function automatic logic is_beq(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPCODE_BRANCH) && (funct3 == FUNCT3_BEQ);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Handshake bundle between the fetch PC unit and its predictor / ID-stage / stats consumers.
interface fetch_pc_unit_if;
  import cpu_pkg::*;

  logic            enable;
  logic            branchTaken;
  logic [XLEN-1:0] predictedBranchPC;
  logic [31:0]     ID_INST;
  logic [XLEN-1:0] branchPC;
  logic            zero_flag;
  logic [XLEN-1:0] IF_PC;
  logic [XLEN-1:0] ID_PC;
  logic            flush;
  logic            redirect;
  logic [31:0]     branchCount;
  logic [31:0]     mispredictCount;

  modport master (
    output enable, branchTaken, predictedBranchPC, ID_INST, branchPC, zero_flag,
    input  IF_PC, ID_PC, flush, redirect, branchCount, mispredictCount
  );

  modport slave (
    input  enable, branchTaken, predictedBranchPC, ID_INST, branchPC, zero_flag,
    output IF_PC, ID_PC, flush, redirect, branchCount, mispredictCount
  );

endinterface

// File: rtl/mispredict_check.sv
// Combinational check of the ID-stage prediction against the resolved BEQ outcome.
module mispredict_check
  import cpu_pkg::*;
#(
  parameter int unsigned InstBytes = INST_BYTES_DEFAULT
) (
  input  if_id_t          id_rec_i,
  input  logic [31:0]     id_inst_i,
  input  logic            zero_flag_i,
  input  logic [XLEN-1:0] branch_pc_i,
  output logic            is_branch_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o
);

  logic actual_taken;
  logic taken_missed;
  logic taken_wrong_target;
  logic false_taken;

  // Only opcode and funct3 matter to branch recognition.
  logic unused_inst;
  assign unused_inst = ^{id_inst_i[31:15], id_inst_i[11:7]};

  always_comb begin
    is_branch_o        = id_rec_i.valid && is_beq(id_inst_i[6:0], id_inst_i[14:12]);
    actual_taken       = is_branch_o && zero_flag_i;
    taken_missed       = actual_taken && !id_rec_i.pred_taken;
    taken_wrong_target = actual_taken && id_rec_i.pred_taken &&
                         (id_rec_i.pred_target != branch_pc_i);
    // Also covers a predicted-taken slot that turned out not to be a BEQ at all.
    false_taken        = id_rec_i.valid && id_rec_i.pred_taken && !actual_taken;
    redirect_o         = taken_missed || taken_wrong_target || false_taken;
    target_o           = (taken_missed || taken_wrong_target) ? branch_pc_i
                                                              : id_rec_i.pc + XLEN'(InstBytes);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC register, IF/ID prediction record and mispredict redirect.
// Optional branch/mispredict counters are built only when BP_STATS_EN is defined.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic           clk,
  input  logic           arst_n,
  fetch_pc_unit_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          rec_q, rec_d;
  logic            redirect;
  logic            is_branch;
  logic [XLEN-1:0] fix_target;

  mispredict_check #(
    .InstBytes (INST_BYTES)
  ) u_mispredict_check (
    .id_rec_i    (rec_q),
    .id_inst_i   (bus.ID_INST),
    .zero_flag_i (bus.zero_flag),
    .branch_pc_i (bus.branchPC),
    .is_branch_o (is_branch),
    .redirect_o  (redirect),
    .target_o    (fix_target)
  );

  always_comb begin
    pc_d  = pc_q;
    rec_d = rec_q;
    if (bus.enable) begin
      if (redirect) begin
        pc_d = fix_target;
      end else if (bus.branchTaken) begin
        pc_d = bus.predictedBranchPC;
      end else begin
        pc_d = pc_q + XLEN'(INST_BYTES);
      end
      // A flushed slot becomes a bubble with no prediction attached.
      rec_d.valid       = !redirect;
      rec_d.pred_taken  = bus.branchTaken && !redirect;
      rec_d.pred_target = redirect ? '0 : bus.predictedBranchPC;
      rec_d.pc          = pc_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q  <= RESET_PC;
      rec_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rec_q <= rec_d;
    end
  end

  assign bus.IF_PC    = pc_q;
  assign bus.ID_PC    = rec_q.pc;
  assign bus.redirect = redirect;
  assign bus.flush    = redirect && bus.enable;

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (is_branch && bus.enable && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (bus.flush && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branchCount     = branch_cnt_q;
  assign bus.mispredictCount = mispred_cnt_q;
`else
  logic unused_is_branch;
  assign unused_is_branch    = is_branch;
  assign bus.branchCount     = '0;
  assign bus.mispredictCount = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit: table of per-cycle vectors plus stall, wrap and reset cases.
module tb_fetch_pc_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Beq = 32'h0000_0063;
  localparam logic [31:0] Bne = 32'h0000_1063;
`ifdef BP_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct {
    logic        en;
    logic        bt;
    logic [63:0] ppc;
    logic [31:0] inst;
    logic [63:0] bpc;
    logic        zf;
    logic [63:0] exp_if;
    logic [63:0] exp_id;
    logic        exp_red;
    logic        exp_fl;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[18];

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic en, logic bt, logic [63:0] ppc, logic [31:0] inst,
                              logic [63:0] bpc, logic zf, logic [63:0] exp_if,
                              logic [63:0] exp_id, logic exp_red, logic exp_fl);
    vec_t v;
    v.en = en; v.bt = bt; v.ppc = ppc; v.inst = inst; v.bpc = bpc; v.zf = zf;
    v.exp_if = exp_if; v.exp_id = exp_id; v.exp_red = exp_red; v.exp_fl = exp_fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic bt, input logic [63:0] ppc,
                       input logic [31:0] inst, input logic [63:0] bpc, input logic zf);
    bus.enable            = en;
    bus.branchTaken       = bt;
    bus.predictedBranchPC = ppc;
    bus.ID_INST           = inst;
    bus.branchPC          = bpc;
    bus.zero_flag         = zf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [63:0] e_if, input logic [63:0] e_id,
                             input logic e_red, input logic e_fl);
    check({tag, " IF_PC"}, bus.IF_PC, e_if);
    check({tag, " ID_PC"}, bus.ID_PC, e_id);
    check({tag, " redirect"}, 64'(bus.redirect), 64'(e_red));
    check({tag, " flush"}, 64'(bus.flush), 64'(e_fl));
  endtask

  task automatic check_counts(input string tag, input int bc, input int mc);
    check({tag, " branchCount"}, 64'(bus.branchCount), Stats ? 64'(bc) : 64'd0);
    check({tag, " mispredictCount"}, 64'(bus.mispredictCount), Stats ? 64'(mc) : 64'd0);
  endtask

  initial begin
    //             en bt ppc     inst bpc     zf  IF       ID       red fl
    tbl[0]  = mk(1, 0, 64'h0,   Nop, 64'h0,   0, 64'h0,   64'h0,   0, 0);
    tbl[1]  = mk(1, 0, 64'h0,   Nop, 64'h0,   0, 64'h4,   64'h0,   0, 0);
    tbl[2]  = mk(1, 1, 64'h100, Nop, 64'h0,   0, 64'h8,   64'h4,   0, 0);
    tbl[3]  = mk(1, 0, 64'h0,   Beq, 64'h100, 1, 64'h100, 64'h8,   0, 0);
    tbl[4]  = mk(1, 1, 64'h20,  Nop, 64'h0,   0, 64'h104, 64'h100, 0, 0);
    tbl[5]  = mk(1, 0, 64'h0,   Beq, 64'h20,  1, 64'h20,  64'h104, 0, 0);
    tbl[6]  = mk(1, 0, 64'h0,   Beq, 64'h80,  1, 64'h24,  64'h20,  1, 1);
    tbl[7]  = mk(1, 0, 64'h0,   Beq, 64'h999, 1, 64'h80,  64'h24,  0, 0);
    tbl[8]  = mk(1, 1, 64'h30,  Nop, 64'h0,   0, 64'h84,  64'h80,  0, 0);
    tbl[9]  = mk(1, 1, 64'h40,  Beq, 64'h30,  1, 64'h30,  64'h84,  0, 0);
    tbl[10] = mk(1, 0, 64'h0,   Beq, 64'h40,  0, 64'h40,  64'h30,  1, 1);
    tbl[11] = mk(1, 0, 64'h0,   Nop, 64'h0,   0, 64'h34,  64'h40,  0, 0);
    tbl[12] = mk(1, 1, 64'h200, Nop, 64'h0,   0, 64'h38,  64'h34,  0, 0);
    tbl[13] = mk(1, 0, 64'h0,   Beq, 64'h300, 1, 64'h200, 64'h38,  1, 1);
    tbl[14] = mk(1, 0, 64'h0,   Nop, 64'h0,   0, 64'h300, 64'h200, 0, 0);
    tbl[15] = mk(1, 1, 64'h500, Nop, 64'h0,   0, 64'h304, 64'h300, 0, 0);
    tbl[16] = mk(1, 0, 64'h0,   Bne, 64'h500, 1, 64'h500, 64'h304, 1, 1);
    tbl[17] = mk(1, 0, 64'h0,   Nop, 64'h0,   0, 64'h308, 64'h500, 0, 0);

    arst_n = 1'b0;
    drive(1, 0, 64'h0, Nop, 64'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 64'h0, 64'h0, 0, 0);
    check_counts("reset", 0, 0);
    arst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].bt, tbl[i].ppc, tbl[i].inst, tbl[i].bpc, tbl[i].zf);
      #1;
      check_state($sformatf("row%0d", i), tbl[i].exp_if, tbl[i].exp_id, tbl[i].exp_red,
                  tbl[i].exp_fl);
      tick();
    end
    check_counts("table", 6, 4);

    // Mispredict pending while stalled: predicted-taken non-branch reaches ID.
    drive(1, 1, 64'h600, Nop, 64'h0, 0);
    #1;
    check("stall setup IF_PC", bus.IF_PC, 64'h30C);
    tick();
    drive(0, 0, 64'h0, Nop, 64'h0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_state($sformatf("stall%0d", k), 64'h600, 64'h30C, 1, 0);
      tick();
    end
    drive(1, 0, 64'h0, Nop, 64'h0, 0);
    #1;
    check_state("stall release", 64'h600, 64'h30C, 1, 1);
    tick();
    #1;
    check_state("stall after", 64'h310, 64'h600, 0, 0);
    check_counts("stall", 6, 5);

    // PC wrap at the top of the address space.
    drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, Nop, 64'h0, 0);
    tick();
    drive(1, 0, 64'h0, Beq, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    #1;
    check_state("wrap pre", 64'hFFFF_FFFF_FFFF_FFFC, 64'h310, 0, 0);
    tick();
    drive(1, 0, 64'h0, Nop, 64'h0, 0);
    #1;
    check_state("wrap post", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    check_counts("wrap", 7, 5);
    tick();
    tick();
    check("run IF_PC", bus.IF_PC, 64'h8);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    #2;
    arst_n = 1'b0;
    #1;
    check_state("midreset", 64'h0, 64'h0, 0, 0);
    check_counts("midreset", 0, 0);
    #1;
    arst_n = 1'b1;
    #1;
    check("post reset IF_PC", bus.IF_PC, 64'h0);
    tick();
    check("first fetch after reset", bus.IF_PC, 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
